// File: rtl/ktms_mmrd_mc_rf.sv
// ktms_mmrd_mc_rf: per-context MMIO read responder; fixed-latency doubleword RAM read, in-order response FIFO, cancel flag.
// Latency: request accepted at T -> o_rd_v at T+ram_lat+1 when the FIFO is empty (registered FIFO storage).
// Backpressure: credit count (in flight + queued) closes i_rd_r at fifo_depth; no RAM stall path. Optional KTMS_MMRD_CTXT_CHK_EN adds context-enable bitmap.
module ktms_mmrd_mc_rf #(
    parameter int ctxtid_width  = 10,
    parameter int lcladdr_width = 4,
    parameter int ram_lat       = 2,
    parameter int fifo_depth    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_rd_v,
    output logic                                  i_rd_r,
    input  logic [lcladdr_width-1:0]              i_rd_addr,
    input  logic [ctxtid_width-1:0]               i_rd_ctxt,
    output logic                                  o_ram_re,
    output logic [ctxtid_width+lcladdr_width-3:0] o_ram_ra,
    input  logic [63:0]                           i_ram_rd,
    input  logic                                  i_ctxt_en_v,
    input  logic [ctxtid_width-2:0]               i_ctxt_en_id,
    input  logic                                  i_ctxt_en_set,
    output logic                                  o_rd_v,
    input  logic                                  o_rd_r,
    output logic [63:0]                           o_rd_d,
    output logic                                  o_rd_cancel,
    output logic                                  o_perror
);

    localparam int IDW  = ctxtid_width - 1;
    localparam int PTRW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNTW = $clog2(fifo_depth + 1);

    // Pipeline tag travelling alongside the RAM access.
    typedef struct packed {
        logic vld;
        logic cancel;
    } tag_t;

    // One response FIFO entry.
    typedef struct packed {
        logic        cancel;
        logic [63:0] dat;
    } rsp_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDW-1:0] req_id;
    logic           par_err;
    logic           ctxt_dis;
    logic           req_cancel;
    logic           accept;
    logic           pop;
    logic           unused_addr_lsb;

    assign req_id          = i_rd_ctxt[ctxtid_width-1:1];
    // Odd parity across id and parity bit; an even XOR means a corrupted context id.
    assign par_err         = ~(^i_rd_ctxt);
    // Word-select bit: the RAM is doubleword addressed.
    assign unused_addr_lsb = i_rd_addr[0];

`ifdef KTMS_MMRD_CTXT_CHK_EN
    logic [2**IDW-1:0] ctxt_en_q;
    logic [2**IDW-1:0] ctxt_en_d;

    // Apply enable/disable strobes; the lookup below sees the old value in the update cycle.
    always_comb begin
        ctxt_en_d = ctxt_en_q;
        if (i_ctxt_en_v) begin
            ctxt_en_d[i_ctxt_en_id] = i_ctxt_en_set;
        end
    end

    // Enable bitmap register; every context starts disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctxt_en_q <= '0;
        end else begin
            ctxt_en_q <= ctxt_en_d;
        end
    end

    assign ctxt_dis = ~ctxt_en_q[req_id];
`else
    logic unused_ctxt_en;

    assign ctxt_dis       = 1'b0;
    assign unused_ctxt_en = ^{i_ctxt_en_v, i_ctxt_en_id, i_ctxt_en_set};
`endif

    assign req_cancel = par_err | ctxt_dis;

    // ------------------------------------------------------------------
    // Credits: slots in flight plus slots queued never exceed the FIFO
    // ------------------------------------------------------------------
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    assign i_rd_r   = (cnt_q < CNTW'(fifo_depth)) & ~reset;
    assign accept   = i_rd_v & i_rd_r;
    assign o_ram_re = accept & ~req_cancel;
    assign o_ram_ra = {req_id, i_rd_addr[lcladdr_width-1:1]};

    // Credit count: take a slot on accept, return it on pop.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline matching the RAM read latency
    // ------------------------------------------------------------------
    tag_t tag_q [ram_lat];
    tag_t tag_d [ram_lat];

    // Shift the tag one stage per cycle; stage 0 loads on the accept cycle.
    always_comb begin
        tag_d[0].vld    = accept;
        tag_d[0].cancel = req_cancel;
        for (int i = 1; i < ram_lat; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag registers; reset drops anything in flight so late RAM data is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ram_lat; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ram_lat; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    logic push;
    rsp_t push_dat;

    // RAM data lines up with the last tag stage; cancelled slots carry zero data.
    always_comb begin
        push            = tag_q[ram_lat-1].vld;
        push_dat.cancel = tag_q[ram_lat-1].cancel;
        push_dat.dat    = tag_q[ram_lat-1].cancel ? 64'h0 : i_ram_rd;
    end

    // ------------------------------------------------------------------
    // Response FIFO (credits guarantee a push never meets a full FIFO)
    // ------------------------------------------------------------------
    rsp_t            fifo_mem_q [fifo_depth];
    logic [PTRW-1:0] wr_ptr_q;
    logic [PTRW-1:0] wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q;
    logic [PTRW-1:0] rd_ptr_d;
    logic [CNTW-1:0] occ_q;
    logic [CNTW-1:0] occ_d;
    rsp_t            rsp_head;

    assign o_rd_v      = (occ_q != '0);
    assign pop         = o_rd_v & o_rd_r;
    assign rsp_head    = fifo_mem_q[rd_ptr_q];
    assign o_rd_d      = rsp_head.dat;
    assign o_rd_cancel = rsp_head.cancel & o_rd_v;

    // Pointer advance modulo fifo_depth and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTRW'(fifo_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(fifo_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // FIFO storage; contents are don't-care until the occupancy says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // ------------------------------------------------------------------
    // Sticky parity error
    // ------------------------------------------------------------------
    logic perror_q;
    logic perror_d;

    // Latch any accepted request that arrived with a bad context parity.
    always_comb begin
        perror_d = perror_q | (accept & par_err);
    end

    // Parity error flag register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perror_q <= 1'b0;
        end else begin
            perror_q <= perror_d;
        end
    end

    assign o_perror = perror_q;

endmodule

// File: tb/tb_ktms_mmrd_mc_rf.sv
// Bench for ktms_mmrd_mc_rf: directed vectors, RAM model with fixed read latency, in-order response scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it or on the falling edge.
// Build with KTMS_MMRD_CTXT_CHK_EN defined to cover the context-enable bitmap.
module tb_ktms_mmrd_mc_rf;

    localparam int CW    = 10;
    localparam int AW    = 4;
    localparam int RLAT  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rd_v;
    logic        i_rd_r;
    logic [3:0]  i_rd_addr;
    logic [9:0]  i_rd_ctxt;
    logic        o_ram_re;
    logic [11:0] o_ram_ra;
    logic [63:0] i_ram_rd;
    logic        i_ctxt_en_v;
    logic [8:0]  i_ctxt_en_id;
    logic        i_ctxt_en_set;
    logic        o_rd_v;
    logic        o_rd_r;
    logic [63:0] o_rd_d;
    logic        o_rd_cancel;
    logic        o_perror;

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        logic [63:0] d;
        logic        c;
    } exp_t;
    exp_t exp_q[$];

`ifdef KTMS_MMRD_CTXT_CHK_EN
    logic en_m [512];
`endif

    always #5 clk = ~clk;

    ktms_mmrd_mc_rf #(
        .ctxtid_width (CW),
        .lcladdr_width(AW),
        .ram_lat      (RLAT),
        .fifo_depth   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rd_v       (i_rd_v),
        .i_rd_r       (i_rd_r),
        .i_rd_addr    (i_rd_addr),
        .i_rd_ctxt    (i_rd_ctxt),
        .o_ram_re     (o_ram_re),
        .o_ram_ra     (o_ram_ra),
        .i_ram_rd     (i_ram_rd),
        .i_ctxt_en_v  (i_ctxt_en_v),
        .i_ctxt_en_id (i_ctxt_en_id),
        .i_ctxt_en_set(i_ctxt_en_set),
        .o_rd_v       (o_rd_v),
        .o_rd_r       (o_rd_r),
        .o_rd_d       (o_rd_d),
        .o_rd_cancel  (o_rd_cancel),
        .o_perror     (o_perror)
    );

    // RAM contents: upper word DEADBEEF tweaked by the word address, lower word the context id.
    function automatic logic [63:0] ram_word(input logic [11:0] ra);
        return {32'hDEADBEEF ^ {29'd0, ra[2:0] ^ 3'd3}, 23'd0, ra[11:3]};
    endfunction

    function automatic logic [9:0] mk(input logic [8:0] id, input logic good);
        return {id, good ? ~(^id) : ^id};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // RAM model: data appears exactly RLAT cycles after a read enable, garbage otherwise.
    logic        s1_v, s2_v;
    logic [11:0] s1_a, s2_a;
    always @(posedge clk) begin
        s1_v <= o_ram_re;
        s1_a <= o_ram_ra;
        s2_v <= s1_v;
        s2_a <= s1_a;
    end
    assign i_ram_rd = s2_v ? ram_word(s2_a) : 64'hBAD0_BAD0_BAD0_BAD0;

    // Scoreboard: check pops in order, record accepts with their expected outcome.
    always @(negedge clk) begin
        exp_t e;
        logic cx;
        if (reset) begin
            exp_q.delete();
`ifdef KTMS_MMRD_CTXT_CHK_EN
            foreach (en_m[i]) en_m[i] = 1'b0;
`endif
        end else begin
            if (o_rd_v && o_rd_r) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_rsp", 64'(o_rd_v), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", o_rd_d, e.d);
                    chk("rsp_can", 64'(o_rd_cancel), 64'(e.c));
                end
            end
            if (i_rd_v && i_rd_r) begin
                cx = ~(^i_rd_ctxt);
`ifdef KTMS_MMRD_CTXT_CHK_EN
                cx = cx | ~en_m[i_rd_ctxt[9:1]];
`endif
                e.c = cx;
                e.d = cx ? 64'h0 : ram_word({i_rd_ctxt[9:1], i_rd_addr[3:1]});
                exp_q.push_back(e);
            end
`ifdef KTMS_MMRD_CTXT_CHK_EN
            if (i_ctxt_en_v) en_m[i_ctxt_en_id] = i_ctxt_en_set;
`endif
        end
    end

    // Single isolated read with exact latency, data, cancel and perror checks.
    task automatic one(input logic [8:0] id, input logic [3:0] addr, input logic good,
                       input logic [63:0] ed, input logic ec, input logic ep0, input logic ep1,
                       input string tg);
        o_rd_r    = 1'b1;
        i_rd_v    = 1'b1;
        i_rd_ctxt = mk(id, good);
        i_rd_addr = addr;
        #1;
        chk({tg, "_rdy"}, 64'(i_rd_r), 1);
        chk({tg, "_re"}, 64'(o_ram_re), 64'(!ec));
        chk({tg, "_ra"}, 64'(o_ram_ra), 64'({id, addr[3:1]}));
        chk({tg, "_perr0"}, 64'(o_perror), 64'(ep0));
        @(posedge clk); #1;
        i_rd_v      = 1'b0;
        i_ctxt_en_v = 1'b0;
        #1;
        chk({tg, "_lat1"}, 64'(o_rd_v), 0);
        chk({tg, "_perr1"}, 64'(o_perror), 64'(ep1));
        @(posedge clk); #2;
        chk({tg, "_lat2"}, 64'(o_rd_v), 0);
        @(posedge clk); #2;
        chk({tg, "_v"}, 64'(o_rd_v), 1);
        chk({tg, "_d"}, o_rd_d, ed);
        chk({tg, "_c"}, 64'(o_rd_cancel), 64'(ec));
        @(posedge clk); #1;
    endtask

    // Present a good-parity request and hold it until accepted.
    task automatic send(input logic [8:0] id, input logic [3:0] addr);
        int n = 0;
        i_rd_v    = 1'b1;
        i_rd_ctxt = mk(id, 1'b1);
        i_rd_addr = addr;
        #1;
        while (!i_rd_r && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!i_rd_r) chk("send_to", 64'(i_rd_r), 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((o_rd_v || exp_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_to", 64'(exp_q.size()), 0);
    endtask

    task automatic init_en();
`ifdef KTMS_MMRD_CTXT_CHK_EN
        for (int i = 0; i < 32; i++) begin
            if (i != 7) begin
                i_ctxt_en_v   = 1'b1;
                i_ctxt_en_id  = 9'(i);
                i_ctxt_en_set = 1'b1;
                @(posedge clk); #1;
            end
        end
        i_ctxt_en_v = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        i_rd_v        = 1'b1;
        i_rd_addr     = 4'h6;
        i_rd_ctxt     = mk(9'd5, 1'b1);
        i_ctxt_en_v   = 1'b0;
        i_ctxt_en_id  = '0;
        i_ctxt_en_set = 1'b0;
        o_rd_r        = 1'b1;

        // Reset state, with a request presented to prove it is refused.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdy", 64'(i_rd_r), 0);
        chk("rst_v", 64'(o_rd_v), 0);
        chk("rst_re", 64'(o_ram_re), 0);
        chk("rst_can", 64'(o_rd_cancel), 0);
        chk("rst_perr", 64'(o_perror), 0);
        i_rd_v = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_rdy1", 64'(i_rd_r), 1);
        @(posedge clk); #1;
        init_en();

        // 1: single read, ctxt 5 addr 6 -> ra {5,3}, data at T+3.
        one(9'd5, 4'h6, 1'b1, 64'hDEADBEEF_00000005, 1'b0, 1'b0, 1'b0, "t1");
        drain();

        // 2: response stalled, six requests -> four accepted, then in-order drain.
        o_rd_r = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_rd_v    = 1'b1;
            i_rd_ctxt = mk(9'(16 + k), 1'b1);
            i_rd_addr = 4'(2 * k);
            #1;
            chk("t2_rdy", 64'(i_rd_r), 64'(k < 4));
            @(posedge clk); #1;
        end
        i_rd_v = 1'b0;
        #1;
        chk("t2_hold_v", 64'(o_rd_v), 1);
        chk("t2_hold_d", o_rd_d, ram_word({9'd16, 3'd0}));
        @(posedge clk); #2;
        chk("t2_hold_d2", o_rd_d, ram_word({9'd16, 3'd0}));
        chk("t2_hold_c2", 64'(o_rd_cancel), 0);
        o_rd_r = 1'b1;
        #1;
        chk("t2_noc", 64'(i_rd_r), 0);
        @(posedge clk); #2;
        chk("t2_reopen", 64'(i_rd_r), 1);
        send(9'd20, 4'h8);
        send(9'd21, 4'hA);
        i_rd_v = 1'b0;
        drain();

        // 3: bad parity on ctxt 3 -> no RAM access, zero data, cancel, sticky perror.
        one(9'd3, 4'h2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t3");
        drain();

        // 4: context enable handling.
`ifdef KTMS_MMRD_CTXT_CHK_EN
        one(9'd7, 4'h0, 1'b1, 64'h0, 1'b1, 1'b1, 1'b1, "t4a");
        i_ctxt_en_v   = 1'b1;
        i_ctxt_en_id  = 9'd7;
        i_ctxt_en_set = 1'b1;
        one(9'd7, 4'h4, 1'b1, 64'h0, 1'b1, 1'b1, 1'b1, "t4b");
        one(9'd7, 4'h4, 1'b1, ram_word({9'd7, 3'd2}), 1'b0, 1'b1, 1'b1, "t4c");
`else
        one(9'd7, 4'h0, 1'b1, ram_word({9'd7, 3'd0}), 1'b0, 1'b1, 1'b1, "t4a");
        i_ctxt_en_v   = 1'b1;
        i_ctxt_en_id  = 9'd9;
        i_ctxt_en_set = 1'b0;
        one(9'd9, 4'h8, 1'b1, ram_word({9'd9, 3'd4}), 1'b0, 1'b1, 1'b1, "t4n");
        one(9'd9, 4'h9, 1'b1, ram_word({9'd9, 3'd4}), 1'b0, 1'b1, 1'b1, "t4m");
`endif
        drain();

        // 5: streaming, one accept per cycle, no bubbles once the pipe is full.
        o_rd_r = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_rd_v    = 1'b1;
            i_rd_ctxt = mk(9'(8 + (k % 16)), 1'b1);
            i_rd_addr = 4'(k);
            #1;
            chk("t5_rdy", 64'(i_rd_r), 1);
            if (k >= RLAT + 1) chk("t5_flow", 64'(o_rd_v), 1);
            @(posedge clk); #1;
        end
        i_rd_v = 1'b0;
        for (int k = 0; k < RLAT + 1; k++) begin
            #1;
            chk("t5_tail", 64'(o_rd_v), 1);
            @(posedge clk); #1;
        end
        #1;
        chk("t5_end", 64'(o_rd_v), 0);
        chk("t5_perr", 64'(o_perror), 1);
        drain();

        // 6: reset with three requests outstanding.
        o_rd_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_rd_v    = 1'b1;
            i_rd_ctxt = mk(9'(10 + k), 1'b1);
            i_rd_addr = 4'(k);
            #1;
            chk("t6_acc", 64'(i_rd_r), 1);
            @(posedge clk); #1;
        end
        i_rd_v = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b0;
        o_rd_r = 1'b1;
        #1;
        chk("t6_rdy", 64'(i_rd_r), 1);
        chk("t6_v", 64'(o_rd_v), 0);
        chk("t6_perr", 64'(o_perror), 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk("t6_quiet", 64'(o_rd_v), 0);
        end
        @(posedge clk); #1;
        init_en();
        one(9'd9, 4'hA, 1'b1, ram_word({9'd9, 3'd5}), 1'b0, 1'b0, 1'b0, "t6b");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
